// File: rtl/mem_arbiter.sv
// mem_arbiter: lets an instruction port and a data port share one memory bus.
// Only one bus transaction is outstanding at a time. The bus is granted in IDLE.
// The data side is favoured until it has won STARVE_MAX address handshakes in a
// row while an instruction request was waiting. After that the instruction side
// is served.
module mem_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  // instruction side
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // shared bus
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR_I = 3'd1,
    ADDR_D = 3'd2,
    WAIT_I = 3'd3,
    WAIT_D = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] starve_cnt_q, starve_cnt_d;
  logic       win_i, win_d;   // IDLE arbitration result
  logic       sel_i, sel_d;   // side currently presenting an address to the bus
  logic       inst_hs, data_hs;

  // State and starvation counter registers; reset abandons any transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // IDLE arbitration: data first unless it has starved the instruction side
  always_comb begin
    win_i = 1'b0;
    win_d = 1'b0;
    if (data_req && (starve_cnt_q < STARVE_LIM)) begin
      win_d = 1'b1;
    end else if (inst_req) begin
      win_i = 1'b1;
    end else if (data_req) begin
      win_d = 1'b1;
    end else begin
      win_i = 1'b0;
      win_d = 1'b0;
    end
  end

  // Which side drives the bus address phase this cycle (none while in reset)
  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    if (rst) begin
      sel_i = 1'b0;
      sel_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sel_i = win_i;
          sel_d = win_d;
        end
        ADDR_I:  sel_i = inst_req;
        ADDR_D:  sel_d = data_req;
        default: begin
          sel_i = 1'b0;
          sel_d = 1'b0;
        end
      endcase
    end
  end

  assign inst_hs = sel_i & bus_addr_ok;
  assign data_hs = sel_d & bus_addr_ok;

  // Next-state logic: lock the grant until the address handshake, then wait for data
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (win_d) begin
          state_d = bus_addr_ok ? WAIT_D : ADDR_D;
        end else if (win_i) begin
          state_d = bus_addr_ok ? WAIT_I : ADDR_I;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR_I: begin
        if (!inst_req) begin
          state_d = IDLE;
        end else if (bus_addr_ok) begin
          state_d = WAIT_I;
        end else begin
          state_d = ADDR_I;
        end
      end
      ADDR_D: begin
        if (!data_req) begin
          state_d = IDLE;
        end else if (bus_addr_ok) begin
          state_d = WAIT_D;
        end else begin
          state_d = ADDR_D;
        end
      end
      WAIT_I:  state_d = bus_data_ok ? IDLE : WAIT_I;
      WAIT_D:  state_d = bus_data_ok ? IDLE : WAIT_D;
      default: state_d = IDLE;
    endcase
  end

  // Starvation counter: count data grants that bypass a waiting inst request
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (inst_hs) begin
      starve_cnt_d = 2'd0;
    end else if (data_hs) begin
      if (!inst_req) begin
        starve_cnt_d = 2'd0;
      end else if (starve_cnt_q < STARVE_LIM) begin
        starve_cnt_d = starve_cnt_q + 2'd1;
      end else begin
        starve_cnt_d = STARVE_LIM;
      end
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Output mux: bus fields from the selected side, zero when the bus is idle
  always_comb begin
    bus_req      = 1'b0;
    bus_wr       = 1'b0;
    bus_size     = 2'b00;
    bus_addr     = 32'd0;
    bus_wdata    = 32'd0;
    inst_addr_ok = inst_hs;
    data_addr_ok = data_hs;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    if (sel_d) begin
      bus_req   = 1'b1;
      bus_wr    = data_wr;
      bus_size  = data_size;
      bus_addr  = data_addr;
      bus_wdata = data_wdata;
    end else if (sel_i) begin
      bus_req   = 1'b1;
      bus_wr    = 1'b0;
      bus_size  = 2'b10;
      bus_addr  = inst_addr;
      bus_wdata = 32'd0;
    end else begin
      bus_req   = 1'b0;
    end
    if (!rst && (state_q == WAIT_I)) begin
      inst_data_ok = bus_data_ok;
    end else if (!rst && (state_q == WAIT_D)) begin
      data_data_ok = bus_data_ok;
    end else begin
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
    end
  end

  assign busy       = (state_q != IDLE);
  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have inst-side ports: inst_req in 1; inst_addr in 32; inst_addr_ok out 1; inst_data_ok out 1; inst_rdata out 32.
REQ-003 SHALL have data-side ports: data_req in 1; data_wr in 1; data_size in 2; data_addr in 32; data_wdata in 32; data_addr_ok out 1; data_data_ok out 1; data_rdata out 32.
REQ-004 SHALL have bus-side ports: bus_req out 1; bus_wr out 1; bus_size out 2; bus_addr out 32; bus_wdata out 32; bus_addr_ok in 1; bus_data_ok in 1; bus_rdata in 32.
REQ-005 SHALL have busy  out  1  high whenever state is not IDLE.
REQ-006 SHALL have parameter STARVE_MAX, default 3, meaning max consecutive data grants while inst_req is pending.

Function
REQ-007 SHALL share the single bus port between the inst and data sides, with at most one outstanding transaction.
REQ-008 SHALL implement states IDLE, ADDR_I, ADDR_D, WAIT_I, WAIT_D.
REQ-009 In IDLE, winner SHALL be data if data_req and starve_cnt < STARVE_MAX; else inst if inst_req; else data if data_req; else none.
REQ-010 In IDLE with a winner, bus_req SHALL be 1 combinationally and the bus fields SHALL be muxed from the winner (inst: bus_wr=0, bus_size=2'b10, bus_wdata=0).
REQ-011 In IDLE, winner-side addr_ok SHALL equal bus_addr_ok; on handshake next state SHALL be WAIT_x, otherwise ADDR_x (grant locked).
REQ-012 In ADDR_x, bus_req SHALL equal x_req, fields SHALL come from side x only, and x_addr_ok SHALL equal bus_addr_ok; on handshake -> WAIT_x.
REQ-013 In ADDR_x, if x_req drops to 0, SHALL return to IDLE next cycle without a handshake.
REQ-014 In WAIT_x, bus_req SHALL be 0; x_data_ok SHALL equal bus_data_ok; on bus_data_ok -> IDLE; the other side's addr_ok and data_ok SHALL be 0.
REQ-015 inst_rdata and data_rdata SHALL both equal bus_rdata combinationally; only the owner's data_ok SHALL assert.
REQ-016 bus_data_ok in IDLE or ADDR_x SHALL be ignored (no data_ok forwarded).
REQ-017 starve_cnt (2-bit) SHALL increment, saturating at STARVE_MAX, on each data address handshake while inst_req=1.
REQ-018 starve_cnt SHALL clear on any inst address handshake or on any data address handshake with inst_req=0.
REQ-019 Latency: request in IDLE with bus_addr_ok=1 SHALL hand off in the same cycle; data_ok SHALL be forwarded the same cycle bus_data_ok arrives (0 added cycles).
REQ-020 Back-to-back: after WAIT_x -> IDLE, a new grant SHALL be possible in the very next cycle.
REQ-021 All unused outputs SHALL be driven to 0 (no X on bus fields when bus_req=0).

Reset
REQ-022 On rst=1, asynchronously: state=IDLE, starve_cnt=0, busy=0; all addr_ok/data_ok/bus_req SHALL be 0 while rst=1.
REQ-023 rst asserted mid-transaction (ADDR_x or WAIT_x) SHALL abandon it; a subsequent late bus_data_ok SHALL not be forwarded.
REQ-024 Outputs after reset release SHALL follow IDLE behaviour from the first clock edge.

Verification
REQ-025 Both req=1 in IDLE, starve_cnt=0, bus_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0, bus_addr=data_addr, next state WAIT_D.
REQ-026 inst_req held, data_req asserted 4 times back-to-back (STARVE_MAX=3) -> 4th grant goes to inst; starve_cnt returns to 0 after inst handshake.
REQ-027 inst_req=1, bus_addr_ok=0 for 3 cycles then 1; data_req rises in cycle 2 -> grant stays inst (ADDR_I), data_addr_ok=0 throughout.
REQ-028 WAIT_D, bus_data_ok=1, bus_rdata=32'hDEADBEEF -> data_data_ok=1, data_rdata=32'hDEADBEEF, inst_data_ok=0; next cycle IDLE, busy=0.
REQ-029 rst pulsed in WAIT_I, then bus_data_ok=1 two cycles later -> inst_data_ok=0, state IDLE.
REQ-030 ADDR_D with data_req dropped to 0 -> next cycle IDLE, bus_req=0, no data_addr_ok pulse.
